// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared types and constants for the JTAG shift engine
package jtag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRST,
        LOW,
        HIGH,
        RESP
    } jtag_state_e;

    localparam logic TMS_IDLE = 1'b1;

    function automatic int jtag_len_w(input int max_bits);
        return (max_bits > 1) ? $clog2(max_bits) : 1;
    endfunction

endpackage

// File: rtl/jtag_tck_phase.sv
// rtl/jtag_tck_phase.sv - TCK half-period counter, pulses phase_done every TCK_HALF clk cycles
module jtag_tck_phase #(
    parameter int TCK_HALF = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic phase_done
);

    localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

    logic [CW-1:0] cnt;

    assign phase_done = !clear && (cnt == CW'(TCK_HALF - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_shift_engine.sv
// rtl/jtag_shift_engine.sv - JTAG bit-bang master; optional JTAG_TDO_SYNC_EN adds a 2-flop tdo synchroniser
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter  int MAX_BITS    = 32,
    parameter  int TCK_HALF    = 5,
    parameter  int TRST_CYCLES = 8,
    localparam int LEN_W       = jtag_len_w(MAX_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_trst,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_tms,
    input  logic [MAX_BITS-1:0] cmd_tdi,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_tdo,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    output logic                trstn,
    input  logic                tdo
);

    localparam int TRST_W = $clog2(TRST_CYCLES + 1);

    typedef struct packed {
        logic                trst;
        logic [LEN_W-1:0]    len;
        logic [MAX_BITS-1:0] tms;
        logic [MAX_BITS-1:0] tdi;
    } jtag_cmd_t;

    jtag_state_e         state, state_d;
    jtag_cmd_t           cmd_in;
    logic [LEN_W-1:0]    idx, idx_d, len_q, len_d;
    logic [MAX_BITS-1:0] tms_vec, tms_vec_d, tdi_vec, tdi_vec_d, rsp_tdo_d;
    logic [TRST_W-1:0]   trst_cnt, trst_cnt_d;
    logic                tck_d, tms_d, tdi_d, trstn_d, cmd_ready_d, rsp_valid_d;
    logic                phase_done, phase_clear, tdo_sample, accept;

`ifdef JTAG_TDO_SYNC_EN
    logic [1:0] tdo_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdo_sync <= '0;
        end else begin
            tdo_sync <= {tdo_sync[0], tdo};
        end
    end

    assign tdo_sample = tdo_sync[1];

    // tdo settles after the falling tck edge; the synchroniser needs 2 cycles before the sample point
    if (TCK_HALF < 3) begin : g_sync_check
        $error("JTAG_TDO_SYNC_EN requires TCK_HALF >= 3");
    end
`else
    assign tdo_sample = tdo;
`endif

    assign phase_clear = !(state == LOW || state == HIGH);
    assign accept      = cmd_valid && cmd_ready;

    jtag_tck_phase #(
        .TCK_HALF(TCK_HALF)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .clear     (phase_clear),
        .phase_done(phase_done)
    );

    always_comb begin
        cmd_in.trst = cmd_trst;
        cmd_in.len  = (32'(cmd_len) > MAX_BITS - 1) ? LEN_W'(MAX_BITS - 1) : cmd_len;
        cmd_in.tms  = cmd_tms;
        cmd_in.tdi  = cmd_tdi;
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        len_d       = len_q;
        tms_vec_d   = tms_vec;
        tdi_vec_d   = tdi_vec;
        trst_cnt_d  = trst_cnt;
        rsp_tdo_d   = rsp_tdo;
        rsp_valid_d = rsp_valid;
        tms_d       = tms;
        tdi_d       = tdi;

        case (state)
            IDLE: begin
                if (accept) begin
                    idx_d      = '0;
                    len_d      = cmd_in.len;
                    tms_vec_d  = cmd_in.tms;
                    tdi_vec_d  = cmd_in.tdi;
                    trst_cnt_d = '0;
                    rsp_tdo_d  = '0;
                    if (cmd_in.trst) begin
                        state_d = TRST;
                    end else begin
                        state_d = LOW;
                        tms_d   = cmd_in.tms[0];
                        tdi_d   = cmd_in.tdi[0];
                    end
                end
            end
            TRST: begin
                if (trst_cnt == TRST_W'(TRST_CYCLES - 1)) begin
                    state_d = RESP;
                end else begin
                    trst_cnt_d = trst_cnt + 1'b1;
                end
            end
            LOW: begin
                if (phase_done) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    rsp_tdo_d[idx] = tdo_sample;
                    if (idx == len_q) begin
                        state_d = RESP;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = LOW;
                        tms_d   = tms_vec[idx_d];
                        tdi_d   = tdi_vec[idx_d];
                    end
                end
            end
            RESP: begin
                // valid rises one cycle after entry, giving the extra latency cycle
                rsp_valid_d = 1'b1;
                if (rsp_valid && rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        tck_d       = (state_d == HIGH);
        trstn_d     = (state_d != TRST);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            len_q     <= '0;
            tms_vec   <= '0;
            tdi_vec   <= '0;
            trst_cnt  <= '0;
            rsp_tdo   <= '0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b0;
            tck       <= 1'b0;
            tms       <= TMS_IDLE;
            tdi       <= 1'b0;
            trstn     <= 1'b1;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            len_q     <= len_d;
            tms_vec   <= tms_vec_d;
            tdi_vec   <= tdi_vec_d;
            trst_cnt  <= trst_cnt_d;
            rsp_tdo   <= rsp_tdo_d;
            rsp_valid <= rsp_valid_d;
            cmd_ready <= cmd_ready_d;
            tck       <= tck_d;
            tms       <= tms_d;
            tdi       <= tdi_d;
            trstn     <= trstn_d;
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb/tb_jtag_shift_engine.sv - randomized self-checking bench with a FIFO model of the TAP data path
module tb_jtag_shift_engine;

    localparam int MB = 32;
    localparam int TH = 5;
    localparam int TR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_trst;
    logic [4:0]    cmd_len;
    logic [MB-1:0] cmd_tms, cmd_tdi;
    logic          rsp_valid, rsp_ready;
    logic [MB-1:0] rsp_tdo;
    logic          tck, tms, tdi, trstn, tdo;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int rises  = 0;
    int trst_lo = 0;
    int acc_cyc = 0;
    logic [63:0] tms_log, tdi_log;
    logic [63:0] sr;
    logic        cap;
    bit          ref_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    jtag_shift_engine #(
        .MAX_BITS   (MB),
        .TCK_HALF   (TH),
        .TRST_CYCLES(TR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_trst (cmd_trst),
        .cmd_len  (cmd_len),
        .cmd_tms  (cmd_tms),
        .cmd_tdi  (cmd_tdi),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_tdo  (rsp_tdo),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .trstn    (trstn),
        .tdo      (tdo)
    );

    // TAP data register: captures tdi on rising tck, shifts on falling tck
    assign tdo = sr[0];
    always @(posedge tck) begin
        cap = tdi;
        if (rises < 64) begin
            tms_log[rises] = tms;
            tdi_log[rises] = tdi;
        end
        rises++;
    end
    always @(negedge tck) sr = {cap, sr[63:1]};
    always @(negedge clk) if (!trstn) trst_lo++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_tap(input logic [63:0] v);
        sr = v;
        ref_q.delete();
        for (int i = 0; i < 64; i++) ref_q.push_back(v[i]);
    endtask

    // Each shifted bit pops the oldest DR bit out as tdo and appends tdi at the far end
    task automatic model(input int len, input logic [31:0] tdiv, output logic [31:0] exp);
        exp = '0;
        for (int i = 0; i <= len; i++) begin
            exp[i] = ref_q.pop_front();
            ref_q.push_back(tdiv[i]);
        end
    endtask

    task automatic start_cmd(input bit trst, input int len, input logic [31:0] tmsv, input logic [31:0] tdiv);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_cmd", cmd_ready, 1);
        rises   = 0;
        trst_lo = 0;
        tms_log = '0;
        tdi_log = '0;
        cmd_trst  = trst;
        cmd_len   = 5'(len);
        cmd_tms   = tmsv;
        cmd_tdi   = tdiv;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_trst  = 1'($urandom);
        cmd_len   = 5'($urandom);
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
    endtask

    task automatic finish_cmd(input bit trst, input int len, input logic [31:0] tmsv,
                              input logic [31:0] tdiv, input logic [31:0] exp, input int hold);
        int n;
        logic [63:0] m;
        n = 0;
        while (!rsp_valid && n < 2 * TH * MB + 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", cyc - acc_cyc, trst ? TR + 1 : 2 * TH * (len + 1) + 1);
        chk("rsp_tdo", rsp_tdo, exp);
        chk("tck_rises", rises, trst ? 0 : len + 1);
        chk("trstn_low_cycles", trst_lo, trst ? TR : 0);
        if (!trst) begin
            m = (len >= 63) ? '1 : ((64'd1 << (len + 1)) - 1);
            chk("tms_sequence", tms_log & m, {32'd0, tmsv} & m);
            chk("tdi_sequence", tdi_log & m, {32'd0, tdiv} & m);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_tdo", rsp_tdo, exp);
            chk("bp_tck", tck, 0);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    task automatic run(input bit trst, input int len, input logic [31:0] tmsv,
                       input logic [31:0] tdiv, input int hold);
        logic [31:0] exp;
        if (trst) exp = '0;
        else model(len, tdiv, exp);
        start_cmd(trst, len, tmsv, tdiv);
        finish_cmd(trst, len, tmsv, tdiv, exp, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_trst = 1'b0;
        cmd_len = '0;
        cmd_tms = '0;
        cmd_tdi = '0;
        rsp_ready = 1'b0;
        load_tap({$urandom, $urandom});
        repeat (3) @(negedge clk);
        chk("reset_tck", tck, 0);
        chk("reset_tms", tms, 1);
        chk("reset_tdi", tdi, 0);
        chk("reset_trstn", trstn, 1);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_tdo", rsp_tdo, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_cmd_ready", cmd_ready, 1);

        run(1'b1, 0, '0, '0, 0);

        v = {$urandom, $urandom};
        v[0] = 1'b1;
        load_tap(v);
        run(1'b0, 0, 32'h1, 32'h1, 0);

        load_tap({$urandom, 32'h1BA0_1477});
        run(1'b0, 31, 32'h0, 32'h0, 0);

        run(1'b0, $urandom_range(0, 31), $urandom, $urandom, 20);

        for (int t = 0; t < 12; t++) begin
            run(($urandom_range(0, 5) == 0), $urandom_range(0, 31), $urandom, $urandom,
                $urandom_range(0, 3));
        end
        run(1'b0, 0, $urandom, $urandom, 1);
        run(1'b0, 31, $urandom, $urandom, 1);

        start_cmd(1'b0, 31, $urandom, $urandom);
        n = 0;
        while (rises < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_bit10", rises >= 10, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_tck", tck, 0);
        chk("async_trstn", trstn, 1);
        chk("async_tms", tms, 1);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_cmd_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_cmd_ready", cmd_ready, 1);
        chk("after_reset_rsp_valid", rsp_valid, 0);
        load_tap({$urandom, $urandom});
        run(1'b0, 3, $urandom, $urandom, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
